// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter in front of a simple dual-port block RAM.
// Writes (port A) and reads (port B) are arbitrated independently, each with
// its own round-robin pointer. Read data returns one cycle after the grant,
// steered to the owning requester with a one-cycle valid strobe.
module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clka,
  input  logic                  rstn,
  input  logic                  req0_i,
  input  logic [3:0]            we0_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [31:0]           wdata0_i,
  output logic                  gnt0_o,
  output logic                  rvalid0_o,
  output logic [31:0]           rdata0_o,
  input  logic                  req1_i,
  input  logic [3:0]            we1_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [31:0]           wdata1_i,
  output logic                  gnt1_o,
  output logic                  rvalid1_o,
  output logic [31:0]           rdata1_o,
  output logic [ADDR_WIDTH-1:0] ram_addra_o,
  output logic [31:0]           ram_dina_o,
  output logic [3:0]            ram_wea_o,
  output logic [ADDR_WIDTH-1:0] ram_addrb_o,
  input  logic [31:0]           ram_doutb_i
);

  // Round-robin pointers: 0 favours requester 0, 1 favours requester 1.
  logic wr_ptr;
  logic rd_ptr;
  // Read-return tracking, one cycle behind the read grant.
  logic rd_pending;
  logic rd_owner;

  logic [ADDR_WIDTH-1:0] addrb_q;
  logic [31:0]           rdata0_q;
  logic [31:0]           rdata1_q;

  logic wr_req0, wr_req1, rd_req0, rd_req1;
  logic wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1;
  logic rd_gnt_any;

  // Classify requests and pick a winner per port; nothing is granted in reset.
  always_comb begin
    wr_req0    = rstn & req0_i & (|we0_i);
    wr_req1    = rstn & req1_i & (|we1_i);
    rd_req0    = rstn & req0_i & ~(|we0_i);
    rd_req1    = rstn & req1_i & ~(|we1_i);
    wr_gnt0    = wr_req0 & (~wr_req1 | ~wr_ptr);
    wr_gnt1    = wr_req1 & (~wr_req0 |  wr_ptr);
    rd_gnt0    = rd_req0 & (~rd_req1 | ~rd_ptr);
    rd_gnt1    = rd_req1 & (~rd_req0 |  rd_ptr);
    rd_gnt_any = rd_gnt0 | rd_gnt1;
    gnt0_o     = wr_gnt0 | rd_gnt0;
    gnt1_o     = wr_gnt1 | rd_gnt1;
  end

  // Steer the winners onto the RAM ports; read address holds when idle.
  always_comb begin
    ram_addra_o = addr0_i;
    ram_dina_o  = wdata0_i;
    ram_wea_o   = 4'b0000;
    ram_addrb_o = addrb_q;
    if (wr_gnt1) begin
      ram_addra_o = addr1_i;
      ram_dina_o  = wdata1_i;
      ram_wea_o   = we1_i;
    end else if (wr_gnt0) begin
      ram_wea_o   = we0_i;
    end
    if (rd_gnt0) begin
      ram_addrb_o = addr0_i;
    end else if (rd_gnt1) begin
      ram_addrb_o = addr1_i;
    end
  end

  // Pointers hand priority to the loser; reset discards any in-flight read.
  always_ff @(posedge clka) begin
    if (!rstn) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      if (wr_gnt0) begin
        wr_ptr <= 1'b1;
      end else if (wr_gnt1) begin
        wr_ptr <= 1'b0;
      end
      if (rd_gnt0) begin
        rd_ptr <= 1'b1;
      end else if (rd_gnt1) begin
        rd_ptr <= 1'b0;
      end
      rd_pending <= rd_gnt_any;
      if (rd_gnt_any) begin
        rd_owner <= rd_gnt1;
      end
    end
  end

  // Data-path holding registers: last read address and last returned words.
  always_ff @(posedge clka) begin
    if (rd_gnt_any) begin
      addrb_q <= ram_addrb_o;
    end
    if (rvalid0_o) begin
      rdata0_q <= ram_doutb_i;
    end
    if (rvalid1_o) begin
      rdata1_q <= ram_doutb_i;
    end
  end

  // Return path: RAM output goes straight to the owner during the valid cycle.
  always_comb begin
    rvalid0_o = rd_pending & ~rd_owner;
    rvalid1_o = rd_pending &  rd_owner;
    rdata0_o  = rvalid0_o ? ram_doutb_i : rdata0_q;
    rdata1_o  = rvalid1_o ? ram_doutb_i : rdata1_q;
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: a read-first RAM model on the RAM ports,
// a table of per-cycle stimulus with expected grants, and a scoreboard of
// expected read returns checked when rvalid is due.
module tb_bram_port_arbiter;

  localparam int AW = 12;

  logic          clka = 1'b0;
  logic          rstn;
  logic          req0, req1;
  logic [3:0]    we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0]   rdata0, rdata1;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [31:0]   ram_dina, ram_doutb;
  logic [3:0]    ram_wea;

  logic [31:0] mem    [0:4095];
  logic [31:0] shadow [0:4095];

  typedef struct {
    logic          rstn;
    logic          drop;
    logic          r0;
    logic [3:0]    we0;
    logic [AW-1:0] a0;
    logic [31:0]   d0;
    logic          r1;
    logic [3:0]    we1;
    logic [AW-1:0] a1;
    logic [31:0]   d1;
    logic          g0;
    logic          g1;
  } vec_t;

  typedef struct {
    int          who;
    logic [31:0] data;
    int          due;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  bram_port_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clka(clka), .rstn(rstn),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .gnt0_o(gnt0), .rvalid0_o(rvalid0), .rdata0_o(rdata0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .gnt1_o(gnt1), .rvalid1_o(rvalid1), .rdata1_o(rdata1),
    .ram_addra_o(ram_addra), .ram_dina_o(ram_dina), .ram_wea_o(ram_wea),
    .ram_addrb_o(ram_addrb), .ram_doutb_i(ram_doutb)
  );

  always #5 clka = ~clka;

  // Read-first block RAM model with registered read port.
  always @(posedge clka) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_wea[b]) mem[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
    end
    ram_doutb <= mem[ram_addrb];
  end

  function automatic vec_t mk(input logic rs, input logic dr,
                              input logic r0, input logic [3:0] w0, input logic [AW-1:0] a0, input logic [31:0] d0,
                              input logic r1, input logic [3:0] w1, input logic [AW-1:0] a1, input logic [31:0] d1,
                              input logic g0, input logic g1);
    vec_t v;
    v.rstn = rs; v.drop = dr;
    v.r0 = r0; v.we0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.we1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic shadow_write(input logic [AW-1:0] a, input logic [3:0] w, input logic [31:0] d);
    for (int b = 0; b < 4; b++) begin
      if (w[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic ev0, ev1;
    exp_t e;
    rstn = v.rstn;
    req0 = v.r0; we0 = v.we0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.we1; addr1 = v.a1; wdata1 = v.d1;
    @(negedge clka);
    ev0 = (sb.size() > 0) && (sb[0].due == cyc) && (sb[0].who == 0);
    ev1 = (sb.size() > 0) && (sb[0].due == cyc) && (sb[0].who == 1);
    chk($sformatf("v%0d rvalid0", idx), {31'd0, rvalid0}, {31'd0, ev0});
    chk($sformatf("v%0d rvalid1", idx), {31'd0, rvalid1}, {31'd0, ev1});
    if (ev0 || ev1) begin
      e = sb.pop_front();
      if (ev0) chk($sformatf("v%0d rdata0", idx), rdata0, e.data);
      else     chk($sformatf("v%0d rdata1", idx), rdata1, e.data);
    end
    chk($sformatf("v%0d gnt0", idx), {31'd0, gnt0}, {31'd0, v.g0});
    chk($sformatf("v%0d gnt1", idx), {31'd0, gnt1}, {31'd0, v.g1});
    if (!v.rstn) chk($sformatf("v%0d wea_in_reset", idx), {28'd0, ram_wea}, 32'd0);
    if (v.rstn) begin
      if (v.g0 && v.we0 == 4'b0) sb.push_back('{0, shadow[v.a0], cyc + 1});
      if (v.g1 && v.we1 == 4'b0) sb.push_back('{1, shadow[v.a1], cyc + 1});
      if (v.g0 && v.we0 != 4'b0) shadow_write(v.a0, v.we0, v.d0);
      if (v.g1 && v.we1 != 4'b0) shadow_write(v.a1, v.we1, v.d1);
    end
    if (v.drop) begin
      rstn = 1'b0;
      sb.delete();
    end
    @(posedge clka);
    cyc++;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'd0;
    end
    mem[12'h010] = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      mem[12'h020 + i] = 32'hA000_0000 + i;
      mem[12'h030 + i] = 32'hB000_0000 + i;
    end
    for (int i = 0; i < 4096; i++) begin
      shadow[i] = mem[i];
    end

    rstn = 1'b0;
    req0 = 1'b0; we0 = 4'h0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 4'h0; addr1 = '0; wdata1 = '0;

    // Reset with requests present: no grants, no write enables.
    vecs.push_back(mk(0,0, 1,4'hF,12'h005,32'h55555555, 1,4'h0,12'h010,32'h0, 0,0));
    vecs.push_back(mk(0,0, 1,4'hF,12'h005,32'h55555555, 1,4'h0,12'h010,32'h0, 0,0));
    // Single read from requester 0, then idle for the return.
    vecs.push_back(mk(1,0, 1,4'h0,12'h010,32'h0, 0,4'h0,12'h000,32'h0, 1,0));
    vecs.push_back(mk(1,0, 0,4'h0,12'h000,32'h0, 0,4'h0,12'h000,32'h0, 0,0));
    // Both writing continuously: grants alternate 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk(1,0, 1,4'hF,12'h001,32'h11111111, 1,4'hF,12'h002,32'h22222222,
                        (i % 2) == 0, (i % 2) == 1));
    end
    // Readback of both words; read pointer now favours requester 1.
    vecs.push_back(mk(1,0, 1,4'h0,12'h001,32'h0, 1,4'h0,12'h002,32'h0, 0,1));
    vecs.push_back(mk(1,0, 1,4'h0,12'h001,32'h0, 0,4'h0,12'h000,32'h0, 1,0));
    vecs.push_back(mk(1,0, 0,4'h0,12'h000,32'h0, 0,4'h0,12'h000,32'h0, 0,0));
    // Same-address write and read in one cycle returns old data; next read new.
    vecs.push_back(mk(1,0, 1,4'hF,12'h0A5,32'h12345678, 1,4'h0,12'h0A5,32'h0, 1,1));
    vecs.push_back(mk(1,0, 0,4'h0,12'h000,32'h0, 1,4'h0,12'h0A5,32'h0, 0,1));
    vecs.push_back(mk(1,0, 0,4'h0,12'h000,32'h0, 0,4'h0,12'h000,32'h0, 0,0));
    // Single-byte write then readback.
    vecs.push_back(mk(1,0, 0,4'h0,12'h000,32'h0, 1,4'b0100,12'h003,32'hAABBCCDD, 0,1));
    vecs.push_back(mk(1,0, 0,4'h0,12'h000,32'h0, 1,4'h0,12'h003,32'h0, 0,1));
    vecs.push_back(mk(1,0, 0,4'h0,12'h000,32'h0, 0,4'h0,12'h000,32'h0, 0,0));
    // Both reading continuously for 6 cycles, advancing address after each grant.
    vecs.push_back(mk(1,0, 1,4'h0,12'h020,32'h0, 1,4'h0,12'h030,32'h0, 1,0));
    vecs.push_back(mk(1,0, 1,4'h0,12'h021,32'h0, 1,4'h0,12'h030,32'h0, 0,1));
    vecs.push_back(mk(1,0, 1,4'h0,12'h021,32'h0, 1,4'h0,12'h031,32'h0, 1,0));
    vecs.push_back(mk(1,0, 1,4'h0,12'h022,32'h0, 1,4'h0,12'h031,32'h0, 0,1));
    vecs.push_back(mk(1,0, 1,4'h0,12'h022,32'h0, 1,4'h0,12'h032,32'h0, 1,0));
    vecs.push_back(mk(1,0, 1,4'h0,12'h023,32'h0, 1,4'h0,12'h032,32'h0, 0,1));
    vecs.push_back(mk(1,0, 0,4'h0,12'h000,32'h0, 0,4'h0,12'h000,32'h0, 0,0));
    // Read granted, reset on the following edge: no return, pointer back to 0.
    vecs.push_back(mk(1,1, 1,4'h0,12'h010,32'h0, 0,4'h0,12'h000,32'h0, 1,0));
    vecs.push_back(mk(0,0, 0,4'h0,12'h000,32'h0, 0,4'h0,12'h000,32'h0, 0,0));
    vecs.push_back(mk(1,0, 1,4'h0,12'h010,32'h0, 1,4'h0,12'h001,32'h0, 1,0));
    vecs.push_back(mk(1,0, 0,4'h0,12'h000,32'h0, 1,4'h0,12'h001,32'h0, 0,1));
    vecs.push_back(mk(1,0, 0,4'h0,12'h000,32'h0, 0,4'h0,12'h000,32'h0, 0,0));

    @(posedge clka);
    #1;
    foreach (vecs[i]) begin
      run_vec(vecs[i], i);
    end
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
